proc_run_ctrl: RTL and testbench

//  Reset/run sequencer for the single-cycle RISC-V Processor. Replaces the fixed

---
 rtl/proc_run_ctrl.sv | 110 +++++++++++
 tb/tb_proc_run_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/proc_run_ctrl.sv
// Reset/run sequencer for the single-cycle RISC-V core: holds the core in reset after start,
// then runs it until halt or cycle-budget expiry, counting run cycles and retired instructions.
module proc_run_ctrl #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned MAX_CYCLES = 14,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_halt,
  input  logic             i_retire,
  output logic             o_core_reset_n,
  output logic             o_running,
  output logic             o_done,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [CNT_W-1:0] o_retire_count
);

  localparam int unsigned HOLD_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRun,
    StDone
  } state_e;

  state_e              r_state;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_core_reset_n;
  logic                r_running;
  logic                r_done;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_cycle_count;
  logic [CNT_W-1:0]    r_retire_count;

  logic [CNT_W-1:0]    w_cycle_inc;
  logic [CNT_W-1:0]    w_retire_inc;
  logic                w_budget_hit;

  // Saturating increments; the budget is checked against the post-increment cycle count.
  always_comb begin
    w_cycle_inc  = (r_cycle_count == '1) ? r_cycle_count : r_cycle_count + CNT_W'(1);
    w_retire_inc = (r_retire_count == '1) ? r_retire_count : r_retire_count + CNT_W'(1);
    w_budget_hit = (MAX_CYCLES != 0) && (w_cycle_inc == CNT_W'(MAX_CYCLES));
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= StIdle;
      r_hold         <= '0;
      r_core_reset_n <= 1'b0;
      r_running      <= 1'b0;
      r_done         <= 1'b0;
      r_timeout      <= 1'b0;
      r_cycle_count  <= '0;
      r_retire_count <= '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_state        <= StHold;
            r_hold         <= '0;
            r_core_reset_n <= 1'b0;
            r_running      <= 1'b0;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;
            r_cycle_count  <= '0;
            r_retire_count <= '0;
          end
        end
        StHold: begin
          // The start edge is hold edge zero, so release happens RST_CYCLES edges after it.
          if (r_hold == HOLD_W'(RST_CYCLES - 1)) begin
            r_state        <= StRun;
            r_core_reset_n <= 1'b1;
            r_running      <= 1'b1;
          end else begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        StRun: begin
          r_cycle_count <= w_cycle_inc;
          if (i_retire) begin
            r_retire_count <= w_retire_inc;
          end
          if (i_halt || w_budget_hit) begin
            r_state   <= StDone;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= !i_halt;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_core_reset_n = r_core_reset_n;
  assign o_running      = r_running;
  assign o_done         = r_done;
  assign o_timeout      = r_timeout;
  assign o_cycle_count  = r_cycle_count;
  assign o_retire_count = r_retire_count;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl: reset, hold timing, halt/timeout endings, restart, mid-run
// asynchronous reset and ignored start in RUN.
module tb_proc_run_ctrl;

  localparam int unsigned CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             halt;
  logic             retire;
  logic             core_reset_n;
  logic             running;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] retire_count;

  int tests_run;
  int tests_failed;

  proc_run_ctrl #(
    .RST_CYCLES(4),
    .MAX_CYCLES(14),
    .CNT_W     (CNT_W)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_start       (start),
    .i_halt        (halt),
    .i_retire      (retire),
    .o_core_reset_n(core_reset_n),
    .o_running     (running),
    .o_done        (done),
    .o_timeout     (timeout),
    .o_cycle_count (cycle_count),
    .o_retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One posedge passes; returns at the following negedge for sampling.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic exp_crn, input logic exp_run,
                              input logic exp_done, input logic exp_to,
                              input int unsigned exp_cyc, input int unsigned exp_ret);
    check({tag, ".core_reset_n"}, 64'(core_reset_n), 64'(exp_crn));
    check({tag, ".running"}, 64'(running), 64'(exp_run));
    check({tag, ".done"}, 64'(done), 64'(exp_done));
    check({tag, ".timeout"}, 64'(timeout), 64'(exp_to));
    check({tag, ".cycle_count"}, 64'(cycle_count), 64'(exp_cyc));
    check({tag, ".retire_count"}, 64'(retire_count), 64'(exp_ret));
  endtask

  // Pulse start, verify the cleared state and the 4-edge hold, end at first RUN cycle.
  task automatic start_run(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_status({tag, ".e0"}, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check({tag, ".hold"}, 64'(core_reset_n), 64'd0);
    end
    tick();
    check_status({tag, ".e4"}, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    start        = 1'b1;
    halt         = 1'b0;
    retire       = 1'b1;

    // 1: start and retire ignored while reset is held
    for (int i = 0; i < 3; i++) begin
      tick();
      check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    end
    start  = 1'b0;
    retire = 1'b0;
    rst_n  = 1'b1;
    tick();
    check_status("idle", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    // 2 + 3: hold timing, then retire every cycle and halt on the 10th RUN cycle
    start_run("run1");
    retire = 1'b1;
    for (int k = 1; k <= 9; k++) tick();
    check_status("run1.c9", 1'b1, 1'b1, 1'b0, 1'b0, 9, 9);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check_status("run1.halt", 1'b1, 1'b0, 1'b1, 1'b0, 10, 10);
    // DONE ignores retire/halt and freezes counts
    halt = 1'b1;
    tick();
    tick();
    halt   = 1'b0;
    retire = 1'b0;
    check_status("run1.frozen", 1'b1, 1'b0, 1'b1, 1'b0, 10, 10);

    // 6 + 4: restart from DONE, retire on odd cycles, no halt -> budget timeout
    start_run("run2");
    for (int k = 1; k <= 14; k++) begin
      retire = (k % 2 == 1);
      tick();
      if (k == 13) check_status("run2.c13", 1'b1, 1'b1, 1'b0, 1'b0, 13, 7);
    end
    retire = 1'b0;
    check_status("run2.timeout", 1'b1, 1'b0, 1'b1, 1'b1, 14, 7);

    // 4b: halt coincides with budget expiry -> halt wins
    start_run("run3");
    retire = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      halt = (k == 14);
      tick();
    end
    halt   = 1'b0;
    retire = 1'b0;
    check_status("run3.halt14", 1'b1, 1'b0, 1'b1, 1'b0, 14, 14);

    // 5: start in RUN ignored, then async reset between edges
    start_run("run4");
    retire = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    check_status("run4.c5", 1'b1, 1'b1, 1'b0, 1'b0, 5, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_status("run4.start_ign", 1'b1, 1'b1, 1'b0, 1'b0, 6, 6);
    #2 rst_n = 1'b0;
    #1;
    check_status("run4.async", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    #1 rst_n = 1'b1;
    retire = 1'b0;
    tick();
    check_status("run4.idle", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
